// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: STANDBY -> READY -> PLAYING -> GAME_OVER, with phases timed in video frames.
// All outputs are registered. startGame pulses on the edge that enters READY, which spends one credit upstream.
module game_flow_ctrl #(
    parameter int READY_FRAMES = 120,
    parameter int OVER_FRAMES  = 300,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       keyStartN,
    input  logic [3:0] credits,
    input  logic       playerDead,
    output logic       startGame,
    output logic       standBy,
    output logic       gameReady,
    output logic       gamePlaying,
    output logic       gameOver,
    output logic       blinkOn
);

    localparam int MAX_RO = (READY_FRAMES > OVER_FRAMES) ? READY_FRAMES : OVER_FRAMES;
    localparam int MAX_F  = (MAX_RO > BLINK_FRAMES) ? MAX_RO : BLINK_FRAMES;
    localparam int CW     = (MAX_F > 1) ? $clog2(MAX_F) : 1;

    localparam logic [CW-1:0] READY_LAST = CW'(READY_FRAMES - 1);
    localparam logic [CW-1:0] OVER_LAST  = CW'(OVER_FRAMES - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_STANDBY = 2'd0,
        ST_READY   = 2'd1,
        ST_PLAYING = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_run_q, blink_run_d;
    logic          blink_on_q, blink_on_d;
    logic          key_q;
    logic          start_game_q, start_game_d;
    logic          standby_q, standby_d;
    logic          ready_q, ready_d;
    logic          playing_q, playing_d;
    logic          over_q, over_d;

    logic start_press;
    logic have_credit;

    assign start_press = key_q & ~keyStartN;
    assign have_credit = (credits != 4'd0);

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        start_game_d = 1'b0;
        case (state_q)
            ST_STANDBY: begin
                // A frame pulse coincident with the press is not counted: the counter starts at 0.
                if (start_press && have_credit) begin
                    state_d      = ST_READY;
                    frame_cnt_d  = '0;
                    start_game_d = 1'b1;
                end
            end
            ST_READY: begin
                if (startOfFrame) begin
                    if (frame_cnt_q == READY_LAST) begin
                        state_d     = ST_PLAYING;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CW'(1);
                    end
                end
            end
            ST_PLAYING: begin
                if (playerDead) begin
                    state_d     = ST_OVER;
                    frame_cnt_d = '0;
                end
            end
            ST_OVER: begin
                if (startOfFrame) begin
                    if (frame_cnt_q == OVER_LAST) begin
                        state_d     = ST_STANDBY;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d     = ST_STANDBY;
                frame_cnt_d = '0;
            end
        endcase

        standby_d = (state_d == ST_STANDBY);
        ready_d   = (state_d == ST_READY);
        playing_d = (state_d == ST_PLAYING);
        over_d    = (state_d == ST_OVER);
    end

    // The blink follows the next state, so blinkOn drops on the same edge that standBy drops.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_run_d = blink_run_q;
        blink_on_d  = blink_on_q;
        if (!(standby_d && have_credit)) begin
            blink_cnt_d = '0;
            blink_run_d = 1'b0;
            blink_on_d  = 1'b0;
        end else if (startOfFrame) begin
            if (!blink_run_q) begin
                blink_run_d = 1'b1;
                blink_on_d  = 1'b1;
                blink_cnt_d = '0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state_q      <= ST_STANDBY;
            frame_cnt_q  <= '0;
            blink_cnt_q  <= '0;
            blink_run_q  <= 1'b0;
            blink_on_q   <= 1'b0;
            key_q        <= 1'b1;
            start_game_q <= 1'b0;
            standby_q    <= 1'b1;
            ready_q      <= 1'b0;
            playing_q    <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_run_q  <= blink_run_d;
            blink_on_q   <= blink_on_d;
            key_q        <= keyStartN;
            start_game_q <= start_game_d;
            standby_q    <= standby_d;
            ready_q      <= ready_d;
            playing_q    <= playing_d;
            over_q       <= over_d;
        end
    end

    assign startGame   = start_game_q;
    assign standBy     = standby_q;
    assign gameReady   = ready_q;
    assign gamePlaying = playing_q;
    assign gameOver    = over_q;
    assign blinkOn     = blink_on_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed phase scenarios plus randomized stimulus against a frame-counting reference model.
module tb_game_flow_ctrl;

    localparam int READY_FRAMES = 120;
    localparam int OVER_FRAMES  = 300;
    localparam int BLINK_FRAMES = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       sof;
    logic       key_n;
    logic [3:0] credits;
    logic       dead;
    logic       startGame, standBy, gameReady, gamePlaying, gameOver, blinkOn;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase number plus how many frames have elapsed in it.
    int m_phase;
    int m_frames;
    int m_blink_n;
    bit m_prev_key;
    bit m_start;

    wire [5:0] dut_out = {startGame, standBy, gameReady, gamePlaying, gameOver, blinkOn};

    game_flow_ctrl #(
        .READY_FRAMES(READY_FRAMES),
        .OVER_FRAMES (OVER_FRAMES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk         (clk),
        .resetN      (rst),
        .startOfFrame(sof),
        .keyStartN   (key_n),
        .credits     (credits),
        .playerDead  (dead),
        .startGame   (startGame),
        .standBy     (standBy),
        .gameReady   (gameReady),
        .gamePlaying (gamePlaying),
        .gameOver    (gameOver),
        .blinkOn     (blinkOn)
    );

    always #5 clk = ~clk;

    function automatic void mdl_reset();
        m_phase    = 0;
        m_frames   = 0;
        m_blink_n  = 0;
        m_prev_key = 1'b1;
        m_start    = 1'b0;
    endfunction

    function automatic void mdl_step();
        bit press;
        if (rst) begin
            mdl_reset();
            return;
        end
        press      = m_prev_key && !key_n;
        m_prev_key = key_n;
        m_start    = 1'b0;
        case (m_phase)
            0: if (press && credits != 0) begin m_phase = 1; m_frames = 0; m_start = 1'b1; end
            1: if (sof) begin
                m_frames++;
                if (m_frames == READY_FRAMES) begin m_phase = 2; m_frames = 0; end
            end
            2: if (dead) begin m_phase = 3; m_frames = 0; end
            default: if (sof) begin
                m_frames++;
                if (m_frames == OVER_FRAMES) begin m_phase = 0; m_frames = 0; end
            end
        endcase
        if (m_phase == 0 && credits != 0) begin
            if (sof) m_blink_n++;
        end else begin
            m_blink_n = 0;
        end
    endfunction

    function automatic logic [5:0] mdl_out();
        logic blink;
        blink = (m_blink_n > 0) && ((((m_blink_n - 1) / BLINK_FRAMES) % 2) == 0);
        return {m_start, m_phase == 0, m_phase == 1, m_phase == 2, m_phase == 3, blink};
    endfunction

    task automatic cyc();
        @(posedge clk);
        mdl_step();
        @(negedge clk);
    endtask

    task automatic frame();
        sof = 1'b1;
        cyc();
        sof = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; sof = 1'b0; key_n = 1'b1; credits = 4'd0; dead = 1'b0;
        mdl_reset();
        repeat (3) cyc();
        checks++;
        if (dut_out !== 6'b010000) begin
            failures++;
            $display("FAIL reset_hold: got %b expected 010000", dut_out);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (dut_out !== 6'b010000) begin
            failures++;
            $display("FAIL reset_release: got %b expected 010000", dut_out);
        end
        for (int i = 0; i < 100; i++) begin
            frame();
            checks++;
            if (blinkOn !== 1'b0 || standBy !== 1'b1) begin
                failures++;
                $display("FAIL idle_no_credit frame %0d: blinkOn=%b standBy=%b expected 0/1", i, blinkOn, standBy);
            end
        end
    endtask

    task automatic test_no_credit_press();
        int pulses = 0;
        key_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) key_n = 1'b1;
            cyc();
            pulses += int'(startGame);
        end
        checks++;
        if (pulses != 0 || standBy !== 1'b1) begin
            failures++;
            $display("FAIL no_credit_press: pulses=%0d standBy=%b expected 0/1", pulses, standBy);
        end
    endtask

    task automatic test_start_game();
        int pulses = 1;
        int n = 0;
        credits = 4'd2;
        key_n = 1'b0;
        cyc();
        checks++;
        if (startGame !== 1'b1 || gameReady !== 1'b1 || standBy !== 1'b0) begin
            failures++;
            $display("FAIL start_edge: startGame=%b gameReady=%b standBy=%b expected 1/1/0", startGame, gameReady, standBy);
        end
        for (int i = 0; i < 49; i++) begin
            cyc();
            pulses += int'(startGame);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL held_key_pulses: got %0d expected 1", pulses);
        end
        key_n = 1'b1;
        while (gamePlaying !== 1'b1 && n < 200) begin
            frame();
            n++;
        end
        checks++;
        if (n != READY_FRAMES) begin
            failures++;
            $display("FAIL ready_duration: got %0d frames expected %0d", n, READY_FRAMES);
        end
    endtask

    task automatic test_game_over();
        int n = 0;
        int pulses = 0;
        dead = 1'b1;
        cyc();
        dead = 1'b0;
        checks++;
        if (gameOver !== 1'b1 || gamePlaying !== 1'b0) begin
            failures++;
            $display("FAIL dead_to_over: gameOver=%b gamePlaying=%b expected 1/0", gameOver, gamePlaying);
        end
        while (standBy !== 1'b1 && n < 400) begin
            frame();
            n++;
            if (n == 10) begin
                key_n = 1'b0;
                cyc();
                pulses += int'(startGame);
                key_n = 1'b1;
                cyc();
                pulses += int'(startGame);
                checks++;
                if (gameOver !== 1'b1) begin
                    failures++;
                    $display("FAIL over_press_ignored: gameOver=%b expected 1", gameOver);
                end
            end
        end
        checks++;
        if (n != OVER_FRAMES || pulses != 0) begin
            failures++;
            $display("FAIL over_duration: got %0d frames %0d pulses expected %0d/0", n, pulses, OVER_FRAMES);
        end
    endtask

    task automatic test_blink();
        logic exp;
        credits = 4'd0;
        cyc();
        credits = 4'd1;
        cyc();
        checks++;
        if (blinkOn !== 1'b0) begin
            failures++;
            $display("FAIL blink_before_frame: got %b expected 0", blinkOn);
        end
        for (int f = 0; f <= 60; f++) begin
            frame();
            exp = ((f / BLINK_FRAMES) % 2) == 0;
            checks++;
            if (blinkOn !== exp) begin
                failures++;
                $display("FAIL blink frame %0d: got %b expected %b", f, blinkOn, exp);
            end
        end
        credits = 4'd0;
        cyc();
        checks++;
        if (blinkOn !== 1'b0) begin
            failures++;
            $display("FAIL blink_credit_drop: got %b expected 0", blinkOn);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        credits = 4'd1;
        key_n = 1'b0;
        cyc();
        key_n = 1'b1;
        repeat (50) frame();
        checks++;
        if (gameReady !== 1'b1) begin
            failures++;
            $display("FAIL mid_ready: gameReady=%b expected 1", gameReady);
        end
        rst = 1'b1;
        mdl_reset();
        #1;
        checks++;
        if (dut_out !== 6'b010000) begin
            failures++;
            $display("FAIL async_reset: got %b expected 010000", dut_out);
        end
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if (startGame !== 1'b0 || standBy !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_quiet: startGame=%b standBy=%b expected 0/1", startGame, standBy);
        end
        key_n = 1'b0;
        cyc();
        key_n = 1'b1;
        checks++;
        if (startGame !== 1'b1 || gameReady !== 1'b1) begin
            failures++;
            $display("FAIL restart_edge: startGame=%b gameReady=%b expected 1/1", startGame, gameReady);
        end
        while (gamePlaying !== 1'b1 && n < 200) begin
            frame();
            n++;
        end
        checks++;
        if (n != READY_FRAMES) begin
            failures++;
            $display("FAIL restart_duration: got %0d frames expected %0d", n, READY_FRAMES);
        end
    endtask

    task automatic test_random();
        logic [5:0] exp;
        for (int i = 0; i < 6000; i++) begin
            sof  = ($urandom_range(0, 2) == 0);
            dead = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) key_n = ~key_n;
            if ($urandom_range(0, 63) == 0) credits = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 2999) == 0) begin
                rst = 1'b1;
                mdl_reset();
            end else begin
                rst = 1'b0;
            end
            cyc();
            exp = mdl_out();
            checks++;
            if (dut_out !== exp) begin
                failures++;
                $display("FAIL random cycle %0d: got %b expected %b", i, dut_out, exp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_credit_press();
        test_start_game();
        test_game_over();
        test_blink();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game-flow state machine; sits directly downstream of credit_block.
- Consumes its `credits` count and raw start key; produces the `startGame` pulse credit_block uses to spend one coin.
- Produces the `standBy` level that credit_block and the start-screen drawers use.
- Sequences standby, get-ready, playing and game-over phases, timed in video frames.

Parameters:
- READY_FRAMES, 120, frames held in READY before PLAYING (about 2 s at 60 Hz).
- OVER_FRAMES, 300, frames held in GAME_OVER before returning to STANDBY.
- BLINK_FRAMES, 30, half-period of the "press start" blink, in frames.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous reset, active-high (asserted = 1)
- startOfFrame  in  1  one-cycle pulse at the start of each video frame
- keyStartN  in  1  start button, active-low, already debounced, level
- credits  in  4  credit count from credit_block, range 0..4
- playerDead  in  1  one-cycle pulse: last life lost
- startGame  out  1  one-cycle pulse: a credit is consumed, game begins
- standBy  out  1  high while in STANDBY
- gameReady  out  1  high while in READY
- gamePlaying  out  1  high while in PLAYING
- gameOver  out  1  high while in GAME_OVER
- blinkOn  out  1  "press start" text enable; toggles every BLINK_FRAMES frames in STANDBY while credits>0, else 0

Behaviour:
- Reset (asynchronous, any state):
  - State STANDBY; frame counter 0; blink counter 0.
  - Key-edge register = 1 (released).
  - Outputs: standBy=1; startGame=0, gameReady=0, gamePlaying=0, gameOver=0, blinkOn=0.
- Start-key edge detect:
  - Registered copy of keyStartN.
  - startPress = previous=1 AND current=0. One cycle per press; a held key gives no repeat.
- STANDBY:
  - If startPress and credits != 0: next cycle state READY, startGame=1 for exactly that one cycle, frame counter cleared.
  - If startPress and credits == 0: ignored, stay in STANDBY, no pulse.
- READY:
  - Frame counter increments on each startOfFrame.
  - When the counter reaches READY_FRAMES-1 and startOfFrame=1: state PLAYING, counter cleared.
  - startPress ignored. playerDead ignored.
- PLAYING:
  - On playerDead=1: state GAME_OVER next cycle, counter cleared.
  - startPress ignored.
- GAME_OVER:
  - Counter increments on each startOfFrame.
  - At OVER_FRAMES-1 with startOfFrame=1: state STANDBY.
  - startPress and playerDead ignored.
- Status outputs:
  - standBy, gameReady, gamePlaying and gameOver are registered, one-hot, and decoded from the current state.
  - They change on the same edge as the state register, so there is zero added latency after the transition edge.
- startGame:
  - Registered; asserts on the edge that enters READY.
  - Never high for two consecutive cycles.
- Credit handling:
  - The credits value is sampled only at startPress in STANDBY.
  - Coins added in other states do not affect this block.
- Blink:
  - The blink counter counts startOfFrame pulses while standBy=1 and credits != 0.
  - At BLINK_FRAMES-1: counter wraps to 0 and blinkOn toggles.
  - If credits == 0 or standBy=0: counter held at 0 and blinkOn=0.
  - blinkOn starts at 1 on the first frame after credits becomes non-zero.
- Counter width: $clog2(max(READY_FRAMES, OVER_FRAMES, BLINK_FRAMES)); must not overflow.
- Simultaneous events:
  - startPress and startOfFrame in the same cycle in STANDBY: the transition occurs and the counter starts at 0; that startOfFrame is not counted.
  - playerDead coincident with the READY→PLAYING edge: ignored.
- Reset mid-game: immediate return to STANDBY; no startGame pulse is emitted on reset release.

Test Plan:
- Reset held 3 cycles then released, credits=0 → standBy=1, all other outputs 0, blinkOn=0 for 100 frames.
- credits=0, keyStartN pulsed low → stays in STANDBY, startGame never asserts.
- credits=2, keyStartN low for 50 cycles → exactly one startGame pulse (1 cycle); gameReady=1 on the same edge; gamePlaying=1 after exactly READY_FRAMES startOfFrame pulses.
- In PLAYING, playerDead pulse → gameOver=1 next edge; standBy=1 after OVER_FRAMES frames; a startPress during GAME_OVER is ignored.
- STANDBY with credits=1 → blinkOn reads 1 for frames 0..29, 0 for 30..59, 1 again at frame 60; credits→0 forces blinkOn=0 the next cycle.
- resetN asserted during READY (frame 50) → standBy=1 asynchronously, counter 0; after release, a new press with credits=1 restarts READY with the full 120 frames.
